key_debounce: RTL and testbench
===============================

# key_debounce

Multi-channel push-button input conditioner that sits between the FPGA key pins and CHIP_TOP, opposite to the led_test output path. Each key is synchronized into the sys_clk domain, debounced by a per-key counter state machine, and presented as a clean level plus single-cycle press and release pulses for the core's GPIO/interrupt logic. All keys are independent and share one clock and one reset.

## Interface

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- CNT_W, 20, debounce counter width.
- DEB_CYCLES, 1000000, stable cycles required before a level change is accepted (20 ms at 50 MHz). Legal range is 2 <= DEB_CYCLES <= 2^CNT_W.
- ACTIVE_LOW, 1. When 1, the pin reads 0 while pressed. When 0, the pin reads 1 while pressed.

Ports:
- sys_clk, input, 1, system clock. All logic is rising-edge.
- sys_rst, input, 1, synchronous, active-high reset.
- key_in, input, NUM_KEYS, raw asynchronous key pins.
- key_level, output, NUM_KEYS, debounced state. 1 means pressed.
- key_press, output, NUM_KEYS, one-cycle pulse when a press is accepted.
- key_release, output, NUM_KEYS, one-cycle pulse when a release is accepted.

## Operation

- Synchronizer: two flops per key (sync1, sync2). Both reset to the inactive pin level (1 if ACTIVE_LOW, else 0).
- Normalization: sample = sync2 XOR ACTIVE_LOW, so sample = 1 means pressed.
- Per-key FSM with four states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED: if sample = 1, go to PRESS_WAIT with cnt = 0.
  - PRESS_WAIT:
    - If sample = 0, return to RELEASED, cnt = 0, no pulse.
    - Else if cnt = DEB_CYCLES-1, go to PRESSED, cnt = 0, and assert key_press for one cycle.
    - Else cnt = cnt+1.
  - PRESSED: if sample = 0, go to RELEASE_WAIT with cnt = 0.
  - RELEASE_WAIT:
    - If sample = 1, return to PRESSED, cnt = 0, no pulse.
    - Else if cnt = DEB_CYCLES-1, go to RELEASED, cnt = 0, and assert key_release for one cycle.
    - Else cnt = cnt+1.
- key_level is registered. It is 1 in PRESSED and RELEASE_WAIT, and 0 in RELEASED and PRESS_WAIT.
- Counter arithmetic:
  - Unsigned, CNT_W bits.
  - It never wraps, because the compare against DEB_CYCLES-1 terminates counting first.
  - cnt is forced to 0 in both stable states.
- Glitch rejection: any opposite sample inside a WAIT state restarts the whole debounce window. A bouncing key therefore produces no pulse until it is stable for DEB_CYCLES consecutive samples.
- Channels are fully independent. Simultaneous activity on several keys produces simultaneous pulses on the matching bits.
- key_press and key_release for one key are never high in the same cycle. At least DEB_CYCLES+1 cycles separate them.

## Timing

- Reset values:
  - key_level = 0, key_press = 0, key_release = 0.
  - All FSMs in RELEASED, all cnt = 0.
  - Sync flops at the inactive level.
- Reset mid-operation: all channels return to the reset values on the next edge. Partial debounce progress is discarded and no pulse is emitted.
- Key held through reset: after sys_rst deasserts, it is debounced as a new press and key_press fires with the normal latency.
- Press latency: let edge 1 be the first sys_clk edge that samples the new stable pin level.
  - Edge 1: sync1 updates.
  - Edge 2: sync2 updates.
  - Edge 3: FSM enters PRESS_WAIT.
  - Edge DEB_CYCLES+3: FSM enters PRESSED. key_press and key_level go high in the cycle after that edge.
- Release latency is the same, DEB_CYCLES+3 edges.
- Pulse width: exactly 1 sys_clk cycle.
- Pin activity shorter than DEB_CYCLES+1 cycles (counted at sync2) never produces a pulse.

## Test plan

Run all scenarios with DEB_CYCLES=8, NUM_KEYS=4, ACTIVE_LOW=1.

- Reset check: hold sys_rst for 5 cycles with key_in = 4'b1111. All outputs must be 0 during reset and stay 0 for 20 cycles after reset.
- Clean press: drive key_in[0] = 0 and hold it.
  - key_press[0] must be high for exactly one cycle, following edge 11 after the change.
  - key_level[0] must rise in the same cycle and stay at 1.
  - Then drive key_in[0] = 1: key_release[0] must pulse 11 edges later and key_level[0] must return to 0.
- Bounce rejection: toggle key_in[1] low for 5 cycles, high for 2, low for 7, high for 1, then low and hold.
  - No pulse may occur during the bouncing.
  - Exactly one key_press[1] must occur, 11 edges after the final low.
- Simultaneous keys: drive key_in[3:2] low on the same edge. key_press[2] and key_press[3] must pulse in the same cycle, and bits 0 and 1 must stay 0.
- Reset mid-debounce: start a press on key 0, then assert sys_rst after 6 cycles for 1 cycle while keeping the pin low.
  - No pulse may occur before reset.
  - After reset, key_press[0] must fire 11 edges after the first post-reset edge.
- Short glitch: drive key_in[0] low for exactly 8 cycles, then high. No key_press[0] may occur and key_level[0] must stay 0.

Source files
------------

// File: rtl/key_debounce.sv
// Multi-channel push-button conditioner: two-flop synchronizer, per-key debounce
// FSM, and a clean pressed level plus one-cycle press/release pulses per key.
module key_debounce #(
  parameter int NUM_KEYS   = 4,
  parameter int CNT_W      = 20,
  parameter int DEB_CYCLES = 1000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic             IDLE_PIN = ACTIVE_LOW;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEB_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] sample;

  // Synchronizer flops rest at the idle pin level so reset never looks like a press.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1 <= {NUM_KEYS{IDLE_PIN}};
      sync2 <= {NUM_KEYS{IDLE_PIN}};
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign sample = sync2 ^ {NUM_KEYS{IDLE_PIN}};

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             press;
    logic             release_p;

    // Any opposite sample during a wait state restarts the whole debounce window.
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        state     <= RELEASED;
        cnt       <= '0;
        level     <= 1'b0;
        press     <= 1'b0;
        release_p <= 1'b0;
      end else begin
        press     <= 1'b0;
        release_p <= 1'b0;
        case (state)
          RELEASED: begin
            cnt   <= '0;
            level <= 1'b0;
            if (sample[k]) state <= PRESS_WAIT;
          end
          PRESS_WAIT: begin
            if (!sample[k]) begin
              state <= RELEASED;
              cnt   <= '0;
            end else if (cnt == LAST_CNT) begin
              state <= PRESSED;
              cnt   <= '0;
              level <= 1'b1;
              press <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          PRESSED: begin
            cnt   <= '0;
            level <= 1'b1;
            if (!sample[k]) state <= RELEASE_WAIT;
          end
          RELEASE_WAIT: begin
            if (sample[k]) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt == LAST_CNT) begin
              state     <= RELEASED;
              cnt       <= '0;
              level     <= 1'b0;
              release_p <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= RELEASED;
            cnt   <= '0;
            level <= 1'b0;
          end
        endcase
      end
    end

    assign key_level[k]   = level;
    assign key_press[k]   = press;
    assign key_release[k] = release_p;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus pushes the expected pulse (cycle and
// masks) and a negedge monitor pops and compares whenever the DUT pulses.
module tb_key_debounce;

  localparam int NUM_KEYS = 4;
  localparam int DEB      = 8;
  localparam int LATENCY  = DEB + 3;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
  } event_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [3:0] key_in;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;

  int     cyc = 0;
  int     total = 0;
  int     bad = 0;
  event_t sb[$];

  key_debounce #(
    .NUM_KEYS  (NUM_KEYS),
    .CNT_W     (4),
    .DEB_CYCLES(DEB),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Drive pins at a negedge, log the expected pulse, then hold for `hold` cycles.
  task automatic applyStimulus(input logic [3:0] pins, input int hold,
                               input logic [3:0] exp_press, input logic [3:0] exp_rel);
    event_t ev;
    key_in = pins;
    if ((exp_press | exp_rel) != 4'b0000) begin
      ev.cyc   = cyc + LATENCY;
      ev.press = exp_press;
      ev.rel   = exp_rel;
      sb.push_back(ev);
    end
    repeat (hold) @(negedge sys_clk);
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput(tag, sb.size(), 0);
    repeat (3) @(negedge sys_clk);
  endtask

  // Every observed pulse must match the oldest outstanding expectation exactly.
  always @(negedge sys_clk) begin
    if ((key_press | key_release) != 4'b0000) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_pulse", {key_press, key_release}, 0);
      end else begin
        event_t ev;
        ev = sb.pop_front();
        checkOutput("pulse_cycle", cyc, ev.cyc);
        checkOutput("press_mask", key_press, ev.press);
        checkOutput("release_mask", key_release, ev.rel);
        checkOutput("level_at_pulse", key_level & (ev.press | ev.rel), ev.press);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    event_t ev;
    sys_rst = 1'b1;
    key_in  = 4'b1111;

    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      checkOutput("reset_outputs", {key_level, key_press, key_release}, 0);
    end
    sys_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      checkOutput("idle_outputs", {key_level, key_press, key_release}, 0);
    end

    $display("[TB] clean press/release on key 0");
    applyStimulus(4'b1110, LATENCY - 1, 4'b0001, 4'b0000);
    checkOutput("level_before_press", key_level, 4'b0000);
    @(negedge sys_clk);
    checkOutput("level_after_press", key_level, 4'b0001);
    repeat (5) @(negedge sys_clk);
    checkOutput("level_held", key_level, 4'b0001);
    applyStimulus(4'b1111, LATENCY - 1, 4'b0000, 4'b0001);
    checkOutput("level_before_release", key_level, 4'b0001);
    @(negedge sys_clk);
    checkOutput("level_after_release", key_level, 4'b0000);
    waitDrain("drain_clean", 40);

    $display("[TB] bounce rejection on key 1");
    applyStimulus(4'b1101, 5, 4'b0000, 4'b0000);
    applyStimulus(4'b1111, 2, 4'b0000, 4'b0000);
    applyStimulus(4'b1101, 7, 4'b0000, 4'b0000);
    applyStimulus(4'b1111, 1, 4'b0000, 4'b0000);
    checkOutput("bounce_level", key_level, 4'b0000);
    applyStimulus(4'b1101, 20, 4'b0010, 4'b0000);
    checkOutput("bounce_settled", key_level, 4'b0010);
    waitDrain("drain_bounce", 40);
    applyStimulus(4'b1111, 20, 4'b0000, 4'b0010);
    waitDrain("drain_bounce_rel", 40);

    $display("[TB] simultaneous keys 2 and 3");
    applyStimulus(4'b0011, 20, 4'b1100, 4'b0000);
    checkOutput("simul_level", key_level, 4'b1100);
    waitDrain("drain_simul", 40);
    applyStimulus(4'b1111, 20, 4'b0000, 4'b1100);
    checkOutput("simul_level_rel", key_level, 4'b0000);
    waitDrain("drain_simul_rel", 40);

    $display("[TB] reset during debounce on key 0");
    applyStimulus(4'b1110, 6, 4'b0000, 4'b0000);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    checkOutput("mid_reset_clear", {key_level, key_press, key_release}, 0);
    sys_rst = 1'b0;
    ev.cyc   = cyc + LATENCY;
    ev.press = 4'b0001;
    ev.rel   = 4'b0000;
    sb.push_back(ev);
    waitDrain("drain_mid_reset", 40);
    checkOutput("mid_reset_level", key_level, 4'b0001);
    applyStimulus(4'b1111, 20, 4'b0000, 4'b0001);
    waitDrain("drain_mid_reset_rel", 40);

    $display("[TB] short glitch on key 0");
    applyStimulus(4'b1110, 0, 4'b0000, 4'b0000);
    for (int i = 0; i < DEB; i++) begin
      @(negedge sys_clk);
      checkOutput("glitch_level_low", key_level, 4'b0000);
    end
    key_in = 4'b1111;
    for (int i = 0; i < 15; i++) begin
      @(negedge sys_clk);
      checkOutput("glitch_level_high", key_level, 4'b0000);
    end
    waitDrain("drain_end", 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
